// File: rtl/frame_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : frame_read_arbiter
//  Purpose  : Shares one frame-buffer read port between the display engine
//             and the stereo engine. Display has priority until the engine
//             has waited MAX_WAIT cycles. After that the engine is forced
//             through for one grant. Reads return a fixed 4 cycles after
//             the grant, routed to whichever requester was granted.
//  Ports    : clk, reset               - clock / sync active-high reset
//             disp_req/addr/gnt        - display request handshake
//             disp_valid/data          - display return pixel
//             eng_req/addr/gnt         - engine request handshake
//             eng_valid/data           - engine return pixel
//             ram_read_address, ram_q  - frame-buffer read port
//  Revision : 1.0  initial release
// ============================================================================
module frame_read_arbiter #(
  parameter int W        = 8,
  parameter int SZ       = 307200,
  parameter int MAX_WAIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  disp_req,
  input  logic [$clog2(SZ)-1:0] disp_addr,
  output logic                  disp_gnt,
  output logic                  disp_valid,
  output logic [W-1:0]          disp_data,
  input  logic                  eng_req,
  input  logic [$clog2(SZ)-1:0] eng_addr,
  output logic                  eng_gnt,
  output logic                  eng_valid,
  output logic [W-1:0]          eng_data,
  output logic [$clog2(SZ)-1:0] ram_read_address,
  input  logic [W-1:0]          ram_q
);

  localparam int                c_aw       = $clog2(SZ);
  localparam logic [c_aw:0]     c_sz       = (c_aw + 1)'(SZ);
  localparam logic [3:0]        c_max_wait = 4'(MAX_WAIT);

  logic [3:0]      starve_q, starve_d;
  logic [c_aw-1:0] raddr_q;
  // Tag pipeline, index 0 is the stage loaded on the grant edge.
  logic [2:0]      tag_v_q, tag_own_q, tag_oor_q;
  logic            disp_valid_q, eng_valid_q;
  logic [W-1:0]    disp_data_q, eng_data_q;

  logic            w_force, w_eng_gnt, w_disp_gnt, w_any;
  logic [c_aw-1:0] w_sel_addr;
  logic            w_oor;

  // Grants are combinational so a requester sees acceptance in the same
  // cycle it asks.
  always_comb begin
    w_force    = (starve_q >= c_max_wait);
    w_eng_gnt  = !reset && eng_req && (w_force || !disp_req);
    w_disp_gnt = !reset && disp_req && !w_eng_gnt;
    w_any      = w_eng_gnt || w_disp_gnt;
    w_sel_addr = w_eng_gnt ? eng_addr : disp_addr;
    w_oor      = ({1'b0, w_sel_addr} >= c_sz);
  end

  // Starve counter only counts while the engine is actively being refused;
  // saturating keeps a misconfigured MAX_WAIT from wrapping back to zero.
  always_comb begin
    starve_d = 4'd0;
    if (eng_req && !w_eng_gnt) begin
      starve_d = (starve_q == 4'd15) ? starve_q : starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q     <= 4'd0;
      raddr_q      <= '0;
      tag_v_q      <= 3'b000;
      tag_own_q    <= 3'b000;
      tag_oor_q    <= 3'b000;
      disp_valid_q <= 1'b0;
      eng_valid_q  <= 1'b0;
      disp_data_q  <= '0;
      eng_data_q   <= '0;
    end else begin
      starve_q <= starve_d;
      // Out-of-range reads leave the RAM address alone; the tag carries the
      // oor flag so the return is zeroed instead.
      if (w_any && !w_oor) begin
        raddr_q <= w_sel_addr;
      end
      tag_v_q   <= {tag_v_q[1:0],   w_any};
      tag_own_q <= {tag_own_q[1:0], w_eng_gnt};
      tag_oor_q <= {tag_oor_q[1:0], w_any && w_oor};
      // Stage 2 lines up with ram_q: address reg + data reg inside the RAM.
      disp_valid_q <= tag_v_q[2] && !tag_own_q[2];
      eng_valid_q  <= tag_v_q[2] &&  tag_own_q[2];
      if (tag_v_q[2] && !tag_own_q[2]) begin
        disp_data_q <= tag_oor_q[2] ? '0 : ram_q;
      end
      if (tag_v_q[2] && tag_own_q[2]) begin
        eng_data_q <= tag_oor_q[2] ? '0 : ram_q;
      end
    end
  end

  assign disp_gnt         = w_disp_gnt;
  assign eng_gnt          = w_eng_gnt;
  assign disp_valid       = disp_valid_q;
  assign disp_data        = disp_data_q;
  assign eng_valid        = eng_valid_q;
  assign eng_data         = eng_data_q;
  assign ram_read_address = raddr_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_frame_read_arbiter
//  Purpose  : Self-checking bench for frame_read_arbiter. A frame-buffer
//             model with two register stages feeds the DUT. A reference
//             model checks every output on every cycle. The model tracks
//             the arbitration rule, a starvation count and a queue of
//             returns due at grant+4. Directed scenarios pin known values.
//  Revision : 1.0  initial release
// ============================================================================
module tb_frame_read_arbiter;

  localparam int W        = 8;
  localparam int SZ       = 307200;
  localparam int MAX_WAIT = 4;
  localparam int AW       = $clog2(SZ);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          disp_req = 1'b0;
  logic [AW-1:0] disp_addr = '0;
  logic          disp_gnt, disp_valid;
  logic [W-1:0]  disp_data;
  logic          eng_req = 1'b0;
  logic [AW-1:0] eng_addr = '0;
  logic          eng_gnt, eng_valid;
  logic [W-1:0]  eng_data;
  logic [AW-1:0] ram_read_address;
  logic [W-1:0]  ram_q;

  frame_read_arbiter #(.W(W), .SZ(SZ), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
    .disp_valid(disp_valid), .disp_data(disp_data),
    .eng_req(eng_req), .eng_addr(eng_addr), .eng_gnt(eng_gnt),
    .eng_valid(eng_valid), .eng_data(eng_data),
    .ram_read_address(ram_read_address), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  // Frame buffer: registered address, registered data.
  logic [W-1:0]  mem [SZ];
  logic [AW-1:0] ram_a1 = '0;
  logic [W-1:0]  ram_q_r = '0;
  always @(posedge clk) begin
    ram_a1  <= ram_read_address;
    ram_q_r <= (int'(ram_a1) < SZ) ? mem[ram_a1] : '0;
  end
  assign ram_q = ram_q_r;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int           due;
    bit           eng;
    logic [W-1:0] data;
  } ret_t;
  ret_t          rq[$];
  ret_t          r;
  int            m_starve = 0;
  logic [AW-1:0] m_raddr  = '0;
  logic [W-1:0]  m_dd     = '0;
  logic [W-1:0]  m_ed     = '0;
  bit            m_eg, m_dg, m_ev, m_dv;
  logic [AW-1:0] m_a;

  always @(negedge clk) begin
    m_eg = !reset && eng_req && (m_starve >= MAX_WAIT || !disp_req);
    m_dg = !reset && disp_req && !m_eg;
    m_ev = 1'b0;
    m_dv = 1'b0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      r = rq.pop_front();
      if (r.eng) begin m_ev = 1'b1; m_ed = r.data; end
      else       begin m_dv = 1'b1; m_dd = r.data; end
    end
    if (cyc >= 1) begin
      chk("m_disp_gnt",   32'(disp_gnt),         32'(m_dg));
      chk("m_eng_gnt",    32'(eng_gnt),          32'(m_eg));
      chk("m_disp_valid", 32'(disp_valid),       32'(m_dv));
      chk("m_eng_valid",  32'(eng_valid),        32'(m_ev));
      chk("m_disp_data",  32'(disp_data),        32'(m_dd));
      chk("m_eng_data",   32'(eng_data),         32'(m_ed));
      chk("m_raddr",      32'(ram_read_address), 32'(m_raddr));
    end
    // advance model across the coming clock edge
    if (reset) begin
      rq.delete();
      m_starve = 0;
      m_raddr  = '0;
      m_dd     = '0;
      m_ed     = '0;
    end else begin
      if (m_eg || m_dg) begin
        m_a = m_eg ? eng_addr : disp_addr;
        if (int'(m_a) < SZ) begin
          rq.push_back('{due: cyc + 4, eng: m_eg, data: mem[m_a]});
          m_raddr = m_a;
        end else begin
          rq.push_back('{due: cyc + 4, eng: m_eg, data: '0});
        end
      end
      if (eng_req && !m_eg) m_starve = (m_starve < 15) ? m_starve + 1 : 15;
      else                  m_starve = 0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 19) == 0)
      return AW'(SZ + int'($urandom_range(0, (1 << AW) - 1 - SZ)));
    return AW'($urandom_range(0, SZ - 1));
  endfunction

  bit p_dg, p_eg;

  initial begin
    for (int i = 0; i < SZ; i++) mem[i] = W'((i * 7) ^ (i >> 5) ^ 8'h3C);
    mem[100] = 8'hA5;

    // Reset state, with both requests asserted to show grants are blocked.
    reset = 1'b1; disp_req = 1'b1; disp_addr = AW'(5); eng_req = 1'b1; eng_addr = AW'(6);
    step(); step();
    at_neg();
    chk("rst_disp_gnt", 32'(disp_gnt), 0);
    chk("rst_eng_gnt",  32'(eng_gnt), 0);
    chk("rst_valids",   32'({disp_valid, eng_valid}), 0);
    chk("rst_data",     32'({disp_data, eng_data}), 0);
    chk("rst_raddr",    32'(ram_read_address), 0);
    step();
    reset = 1'b0; disp_req = 1'b0; eng_req = 1'b0;
    step(); step();

    // Single display read of address 100.
    disp_req = 1'b1; disp_addr = AW'(100);
    at_neg();
    chk("t1_disp_gnt", 32'(disp_gnt), 1);
    chk("t1_eng_gnt",  32'(eng_gnt), 0);
    step();
    disp_req = 1'b0;
    at_neg();
    chk("t1_raddr", 32'(ram_read_address), 100);
    for (int k = 2; k <= 5; k++) begin
      step();
      at_neg();
      chk("t1_disp_valid", 32'(disp_valid), (k == 4) ? 1 : 0);
      if (k >= 4) chk("t1_disp_data", 32'(disp_data), 32'h A5);
    end
    step(); step(); step();

    // Starvation with both requesters held continuously.
    disp_req = 1'b1; disp_addr = AW'(200); eng_req = 1'b1; eng_addr = AW'(300);
    for (int i = 0; i < 10; i++) begin
      at_neg();
      chk("t2_disp_gnt", 32'(disp_gnt), (i != 4 && i != 9) ? 1 : 0);
      chk("t2_eng_gnt",  32'(eng_gnt),  (i == 4 || i == 9) ? 1 : 0);
      step();
    end
    disp_req = 1'b0; eng_req = 1'b0;
    repeat (6) step();

    // Engine back-to-back reads of addresses 0..9.
    for (int i = 0; i < 15; i++) begin
      eng_req  = (i < 10);
      eng_addr = AW'(i);
      at_neg();
      if (i < 10) chk("t3_eng_gnt", 32'(eng_gnt), 1);
      chk("t3_eng_valid", 32'(eng_valid), (i >= 4 && i < 14) ? 1 : 0);
      if (i >= 4 && i < 14) chk("t3_eng_data", 32'(eng_data), 32'(mem[i - 4]));
      chk("t3_disp_valid", 32'(disp_valid), 0);
      step();
    end
    eng_req = 1'b0;
    repeat (3) step();

    // Out-of-range engine address.
    eng_req = 1'b1; eng_addr = AW'(SZ);
    at_neg();
    chk("t4_eng_gnt", 32'(eng_gnt), 1);
    step();
    eng_req = 1'b0;
    at_neg();
    chk("t4_raddr", 32'(ram_read_address), 9);
    for (int k = 2; k <= 4; k++) begin
      step();
      at_neg();
      chk("t4_eng_valid", 32'(eng_valid), (k == 4) ? 1 : 0);
      if (k == 4) chk("t4_eng_data", 32'(eng_data), 0);
    end
    step(); step(); step();

    // Reset while reads are in flight.
    for (int i = 0; i < 3; i++) begin
      disp_req = 1'b1; disp_addr = AW'(10 + i);
      at_neg();
      chk("t5_disp_gnt", 32'(disp_gnt), 1);
      step();
    end
    disp_addr = AW'(13);
    reset = 1'b1;
    at_neg();
    chk("t5_rst_gnt", 32'(disp_gnt), 0);
    step();
    reset = 1'b0; disp_req = 1'b1; disp_addr = AW'(50);
    at_neg();
    chk("t5_resume_gnt", 32'(disp_gnt), 1);
    chk("t5_raddr",      32'(ram_read_address), 0);
    chk("t5_data",       32'({disp_data, eng_data}), 0);
    chk("t5_valid4",     32'({disp_valid, eng_valid}), 0);
    step();
    disp_req = 1'b0;
    for (int i = 5; i <= 6; i++) begin
      at_neg();
      chk("t5_valid", 32'({disp_valid, eng_valid}), 0);
      step();
    end
    repeat (4) step();

    // Randomized traffic with occasional resets.
    p_dg = 1'b0; p_eg = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (disp_req && p_dg) disp_req = 1'b0;
      if (eng_req && p_eg)  eng_req  = 1'b0;
      if (!disp_req && $urandom_range(0, 99) < 80) begin
        disp_req = 1'b1; disp_addr = rand_addr();
      end
      if (!eng_req && $urandom_range(0, 99) < 50) begin
        eng_req = 1'b1; eng_addr = rand_addr();
      end
      reset = ($urandom_range(0, 249) == 0);
      at_neg();
      p_dg = disp_gnt;
      p_eg = eng_gnt;
      step();
    end
    reset = 1'b0; disp_req = 1'b0; eng_req = 1'b0;
    repeat (8) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
